// File: rtl/core_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : core_dispatcher
// Purpose  : Delivers one task instruction word to every core named in a task
//            mask. At most one core is served per cycle, picked round-robin
//            among cores that are still pending and ready. An optional fence
//            holds off the next task until every targeted core has reported
//            completion.
// Ports    :
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   task_valid     task offered by the scheduler
//   task_ready     dispatcher idle and able to accept a task
//   task_mask      target cores (bit i = core i)
//   task_instr     instruction word for the targeted cores
//   task_fence     wait for core_done from all targets before the next task
//   core_ready     per-core "can take a message this cycle"
//   core_done      per-core single-cycle completion pulse
//   mess_to_core   registered message data (zero-extended instruction)
//   mess_valid     registered one-hot strobe selecting the receiving core
//   busy           dispatcher not idle
//   err_empty_mask one-cycle pulse: an all-zero mask task was accepted
// Revision : 1.0 - initial release
// ============================================================================
module core_dispatcher #(
  parameter int CORE_NUM    = 16,
  parameter int BUS_TO_CORE = 16,
  parameter int INSTR_SIZE  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   task_valid,
  output logic                   task_ready,
  input  logic [CORE_NUM-1:0]    task_mask,
  input  logic [INSTR_SIZE-1:0]  task_instr,
  input  logic                   task_fence,
  input  logic [CORE_NUM-1:0]    core_ready,
  input  logic [CORE_NUM-1:0]    core_done,
  output logic [BUS_TO_CORE-1:0] mess_to_core,
  output logic [CORE_NUM-1:0]    mess_valid,
  output logic                   busy,
  output logic                   err_empty_mask
);

  localparam int PTR_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_FENCE    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CORE_NUM-1:0]     pending_q, pending_d;
  logic [CORE_NUM-1:0]     outstanding_q, outstanding_d;
  logic [INSTR_SIZE-1:0]   instr_q, instr_d;
  logic                    fence_q, fence_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CORE_NUM-1:0]     mess_valid_q, mess_valid_d;
  logic [BUS_TO_CORE-1:0]  mess_to_core_q, mess_to_core_d;
  logic                    err_q, err_d;

  logic [CORE_NUM-1:0]     eligible;
  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic [CORE_NUM-1:0]     grant_onehot;
  logic [CORE_NUM-1:0]     set_bits;
  logic                    accept;
  logic [CORE_NUM-1:0]     still_outstanding;

  assign eligible          = pending_q & core_ready;
  assign still_outstanding = outstanding_q & ~core_done;

  // Round-robin search: walk from rr_ptr upward, wrapping at the top index;
  // the first eligible core wins.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < CORE_NUM; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= CORE_NUM) begin
        idx = idx - CORE_NUM;
      end
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign grant_onehot = grant_found ? (CORE_NUM'(1) << grant_idx) : '0;

  // Next-state and datapath
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    instr_d        = instr_q;
    fence_d        = fence_q;
    rr_ptr_d       = rr_ptr_q;
    mess_valid_d   = '0;
    mess_to_core_d = mess_to_core_q;
    err_d          = 1'b0;
    set_bits       = '0;
    accept         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (task_valid) begin
          if (task_mask == '0) begin
            // Empty task is dropped; only the error pulse is raised.
            err_d = 1'b1;
          end else begin
            accept    = 1'b1;
            pending_d = task_mask;
            instr_d   = task_instr;
            fence_d   = task_fence;
            state_d   = S_DISPATCH;
          end
        end
      end

      S_DISPATCH: begin
        if (grant_found) begin
          mess_valid_d   = grant_onehot;
          mess_to_core_d = BUS_TO_CORE'(instr_q);
          pending_d      = pending_q & ~grant_onehot;
          set_bits       = grant_onehot;
          rr_ptr_d       = (grant_idx == PTR_W'(CORE_NUM - 1)) ? '0 : grant_idx + 1'b1;
          if ((pending_q & ~grant_onehot) == '0) begin
            state_d = fence_q ? S_FENCE : S_IDLE;
          end
        end
      end

      S_FENCE: begin
        // Exit may use this cycle's core_done, not just the registered state.
        if (still_outstanding == '0) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A grant in the same cycle as a stale core_done keeps the bit set:
    // that done pulse belonged to the core's previous task.
    if (accept) begin
      outstanding_d = '0;
    end else begin
      outstanding_d = still_outstanding | set_bits;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pending_q      <= '0;
      outstanding_q  <= '0;
      instr_q        <= '0;
      fence_q        <= 1'b0;
      rr_ptr_q       <= '0;
      mess_valid_q   <= '0;
      mess_to_core_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      outstanding_q  <= outstanding_d;
      instr_q        <= instr_d;
      fence_q        <= fence_d;
      rr_ptr_q       <= rr_ptr_d;
      mess_valid_q   <= mess_valid_d;
      mess_to_core_q <= mess_to_core_d;
      err_q          <= err_d;
    end
  end

  assign task_ready     = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign mess_valid     = mess_valid_q;
  assign mess_to_core   = mess_to_core_q;
  assign err_empty_mask = err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_dispatcher
// Purpose  : Self-checking bench for core_dispatcher. Expected strobes
//            ({mess_valid, mess_to_core}) are queued as each task is driven
//            and popped whenever the DUT raises mess_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_dispatcher;

  logic        clk;
  logic        reset;
  logic        task_valid;
  logic        task_ready;
  logic [15:0] task_mask;
  logic [15:0] task_instr;
  logic        task_fence;
  logic [15:0] core_ready;
  logic [15:0] core_done;
  logic [15:0] mess_to_core;
  logic [15:0] mess_valid;
  logic        busy;
  logic        err_empty_mask;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  core_dispatcher #(
    .CORE_NUM    (16),
    .BUS_TO_CORE (16),
    .INSTR_SIZE  (16)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .task_valid     (task_valid),
    .task_ready     (task_ready),
    .task_mask      (task_mask),
    .task_instr     (task_instr),
    .task_fence     (task_fence),
    .core_ready     (core_ready),
    .core_done      (core_done),
    .mess_to_core   (mess_to_core),
    .mess_valid     (mess_valid),
    .busy           (busy),
    .err_empty_mask (err_empty_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (mess_valid !== 16'h0000) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {mess_valid, mess_to_core}, 32'h0);
      end else begin
        mon_exp = sb.pop_front();
        check("strobe", {mess_valid, mess_to_core}, mon_exp);
      end
    end
  end

  task automatic push(input logic [15:0] mv, input logic [15:0] data);
    sb.push_back({mv, data});
  endtask

  // Offer a task for exactly one edge (dispatcher must be idle).
  task automatic send_task(input logic [15:0] mask, input logic [15:0] instr, input logic fence);
    task_valid = 1'b1;
    task_mask  = mask;
    task_instr = instr;
    task_fence = fence;
    @(posedge clk);
    #1;
    task_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(task_ready && sb.size() == 0) && n < 200);
    check("drain_queue", 32'(sb.size()), 32'h0);
    check("drain_ready", {31'h0, task_ready}, 32'h1);
  endtask

  initial begin
    reset      = 1'b1;
    task_valid = 1'b0;
    task_mask  = '0;
    task_instr = '0;
    task_fence = 1'b0;
    core_ready = 16'hFFFF;
    core_done  = '0;

    // Reset state
    #2;
    check("rst_mess_valid", {16'h0, mess_valid}, 32'h0);
    check("rst_mess_data",  {16'h0, mess_to_core}, 32'h0);
    check("rst_err",        {31'h0, err_empty_mask}, 32'h0);
    check("rst_busy",       {31'h0, busy}, 32'h0);
    check("rst_ready",      {31'h0, task_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // All ready, no fence
    push(16'h0010, 16'hABCD);
    push(16'h0020, 16'hABCD);
    push(16'h0040, 16'hABCD);
    push(16'h0080, 16'hABCD);
    send_task(16'h00F0, 16'hABCD, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check("t1_last_strobe", {16'h0, mess_valid}, 32'h0080);
    check("t1_ready_with_last", {31'h0, task_ready}, 32'h1);
    wait_idle();

    // Round-robin wrap from pointer 8
    push(16'h0100, 16'h1111);
    push(16'h8000, 16'h1111);
    push(16'h0001, 16'h1111);
    send_task(16'h8101, 16'h1111, 1'b0);
    wait_idle();

    // Ready gating: core 1 not ready for a while
    core_ready = 16'hFFFD;
    push(16'h0004, 16'h2222);
    push(16'h0002, 16'h2222);
    send_task(16'h0006, 16'h2222, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("gate_gap_strobe", {16'h0, mess_valid}, 32'h0);
    check("gate_gap_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    core_ready = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("gate_late_grant", {16'h0, mess_valid}, 32'h0002);
    wait_idle();

    // Fence, with a second task held valid throughout
    push(16'h0001, 16'h5A5A);
    push(16'h0002, 16'h5A5A);
    push(16'h0010, 16'h1234);
    send_task(16'h0003, 16'h5A5A, 1'b1);
    task_valid = 1'b1;
    task_mask  = 16'h0010;
    task_instr = 16'h1234;
    task_fence = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    core_done = 16'h0001;
    @(negedge clk);
    check("fence_busy", {31'h0, busy}, 32'h1);
    check("fence_not_ready", {31'h0, task_ready}, 32'h0);
    @(posedge clk);
    #1;
    core_done = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    core_done = 16'h0002;
    @(negedge clk);
    check("fence_hold", {31'h0, task_ready}, 32'h0);
    @(posedge clk);
    #1;
    core_done = 16'h0000;
    @(negedge clk);
    check("fence_release", {31'h0, task_ready}, 32'h1);
    @(posedge clk);
    #1;
    task_valid = 1'b0;
    @(negedge clk);
    check("fence_second_accepted", {31'h0, task_ready}, 32'h0);
    wait_idle();

    // Empty mask
    task_valid = 1'b1;
    task_mask  = 16'h0000;
    task_instr = 16'h9999;
    task_fence = 1'b0;
    #1;
    check("empty_err_before", {31'h0, err_empty_mask}, 32'h0);
    @(posedge clk);
    #1;
    task_valid = 1'b0;
    @(negedge clk);
    check("empty_err_pulse", {31'h0, err_empty_mask}, 32'h1);
    check("empty_stay_idle", {31'h0, task_ready}, 32'h1);
    check("empty_no_strobe", {16'h0, mess_valid}, 32'h0);
    @(negedge clk);
    check("empty_err_clear", {31'h0, err_empty_mask}, 32'h0);

    // Async reset mid-dispatch (pointer currently at 5)
    push(16'h0020, 16'hC3C3);
    push(16'h0040, 16'hC3C3);
    push(16'h0080, 16'hC3C3);
    send_task(16'hFFFF, 16'hC3C3, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_mess_valid", {16'h0, mess_valid}, 32'h0);
    check("arst_ready", {31'h0, task_ready}, 32'h1);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_queue", 32'(sb.size()), 32'h0);
    #1;
    reset = 1'b0;
    push(16'h0001, 16'h7777);
    push(16'h8000, 16'h7777);
    send_task(16'h8001, 16'h7777, 1'b0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_dispatcher.md
# core_dispatcher

Distributes one instruction word at a time to the group of cores named by a task mask. Each cycle it delivers to at most one core, chosen round-robin among the cores that are both still pending and ready. It can optionally hold off the next task until every targeted core reports completion, acting as a barrier. It sits between the scheduler's task output and the per-core message bus.

## Interface
- CORE_NUM, 16: number of cores; also the width of all masks.
- BUS_TO_CORE, 16: width of the shared message bus.
- INSTR_SIZE, 16: width of the task instruction word; must be ≤ BUS_TO_CORE, zero-extended onto the bus.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- task_valid  in  1  a task is offered.
- task_ready  out  1  the dispatcher can accept a task.
- task_mask  in  CORE_NUM  target cores; bit i selects core i.
- task_instr  in  INSTR_SIZE  word delivered to every targeted core.
- task_fence  in  1  1 = wait for core_done from every targeted core before the next task.
- core_ready  in  CORE_NUM  core i can take a message this cycle.
- core_done  in  CORE_NUM  single-cycle pulse: core i finished its current task.
- mess_to_core  out  BUS_TO_CORE  registered message data.
- mess_valid  out  CORE_NUM  registered one-hot strobe; bit i = mess_to_core is for core i this cycle.
- busy  out  1  state != IDLE.
- err_empty_mask  out  1  registered single-cycle pulse: a task with an all-zero mask was accepted.

## Operation
- States: IDLE, DISPATCH, FENCE. Two-bit state register, reset to IDLE.
- Registers:
  - pending[CORE_NUM]: cores not yet served.
  - outstanding[CORE_NUM]: cores served but not yet done.
  - instr_q: latched task_instr.
  - fence_q: latched task_fence.
  - rr_ptr[log2 CORE_NUM]: round-robin pointer.
- task_ready = (state == IDLE). It is a Moore output.
- **IDLE**, handshake task_valid & task_ready:
  - If task_mask == 0: pulse err_empty_mask the next cycle and stay in IDLE. The task is dropped.
  - Otherwise: pending <= task_mask, outstanding <= 0, instr_q <= task_instr, fence_q <= task_fence, and go to DISPATCH.
- **DISPATCH**:
  - eligible = pending & core_ready.
  - grant = first set bit of eligible, searching from index rr_ptr upward and wrapping at CORE_NUM-1 to 0.
  - If eligible != 0, at the edge:
    - mess_valid <= onehot(grant).
    - mess_to_core <= zero-extended instr_q.
    - pending[grant] <= 0.
    - outstanding[grant] <= 1.
    - rr_ptr <= (grant+1) mod CORE_NUM.
  - If eligible == 0: mess_valid <= 0 and state is held. There is no timeout.
  - When the bit being cleared is the last pending bit: go to FENCE if fence_q, else IDLE.
- **FENCE**:
  - mess_valid <= 0.
  - Leave for IDLE at the edge where (outstanding & ~core_done) == 0.
- outstanding update every edge: outstanding <= (outstanding & ~core_done) | set_bit. If set and clear hit the same bit in the same cycle, set wins, because that core_done belongs to an earlier task.
- core_done for cores not in outstanding is ignored.
- rr_ptr is not reset between tasks, which gives fairness across tasks.
- Outside DISPATCH grant cycles, mess_valid is 0 and mess_to_core holds its last value.

## Timing
- Reset (async assert): state=IDLE, pending=0, outstanding=0, rr_ptr=0, mess_valid=0, mess_to_core=0, err_empty_mask=0, busy=0, task_ready=1.
- Reset mid-task aborts with no further strobes; the in-flight task is lost.
- Task accepted at edge N. If all targeted cores are ready, their strobes appear in the cycles after edges N+1 … N+k, one per cycle, for k = popcount(mask).
- Without fence, the state returns to IDLE at edge N+k. task_ready is high in the same cycle as the last strobe, so the next task can be accepted at edge N+k+1.
- With fence, exit happens at the first edge ≥ N+k+1 at which all outstanding bits are cleared, or are cleared by that cycle's core_done. Minimum latency to task_ready is one cycle after the last strobe.
- A core dropping core_ready only delays its own grant. Others continue round-robin.
- Maximum throughput: one core per cycle. A full 16-core mask with no fence takes 16 cycles of DISPATCH.

## Test plan
- **All ready, no fence:** reset, mask=16'h00F0, instr=16'hABCD, all ready -> mess_valid = 0x0010, 0x0020, 0x0040, 0x0080 on 4 consecutive cycles, data ABCD throughout; task_ready high in the cycle of the 0x0080 strobe; rr_ptr=8.
- **Round-robin wrap:** after the previous test, mask=16'h8101 -> order is core 8, 15, 0 (strobes 0x0100, 0x8000, 0x0001).
- **Ready gating:** mask=16'h0006, core_ready[1]=0 for 5 cycles -> core 2 is served first; core 1 is served in the first cycle after core_ready[1] rises; no strobe in the gap cycles.
- **Fence:** mask=16'h0003, fence=1 -> after 2 strobes, busy stays 1. core_done[0] pulses at +3, then core_done[1] at +6 -> task_ready rises the cycle after +6. A second task_valid held throughout is accepted only then.
- **Empty mask:** mask=0 with task_valid -> err_empty_mask pulses for 1 cycle, no mess_valid, state stays IDLE.
- **Async reset mid-dispatch:** mask=16'hFFFF, reset asserted between edges after 3 strobes -> mess_valid=0 and task_ready=1 immediately, without waiting for clk; the next task begins from core 0.
